uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry.
// Used by the receiver now and by the transmitter later.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;  // br_tick pulses per bit period
    localparam int UART_DATA_BITS  = 8;   // payload bits per frame

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// The reset value is a parameter so an idle-high line resets to 1.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Shift the async input through two flops to settle metastability
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1-style frame decoder.
// Ticks come from an external baud generator; the start bit is confirmed
// at its centre and every following bit is sampled one bit period later.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 br_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rx_s;

    uart_state_t          state_reg, state_next;
    logic [TW-1:0]        tick_reg,  tick_next;
    logic [BW-1:0]        bit_reg,   bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_reg,  data_next;
    logic                 done_reg,  done_next;
    logic                 ferr_reg,  ferr_next;

    logic mid_tick;     // centre of the start bit
    logic sample_tick;  // centre of a data or stop bit

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign mid_tick    = br_tick && (tick_reg == TICK_MID);
    assign sample_tick = br_tick && (tick_reg == TICK_LAST);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            tick_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            done_reg  <= done_next;
            ferr_reg  <= ferr_next;
        end
    end

    // Next-state decisions, all made on the synchronized line
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (!rx_s) state_next = ST_START;
            ST_START: if (mid_tick) state_next = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (sample_tick && (bit_reg == BIT_LAST)) state_next = ST_STOP;
            ST_STOP:  if (sample_tick) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Counters, shift register and registered frame results
    always_comb begin
        tick_next  = tick_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        done_next  = 1'b0;
        ferr_next  = ferr_reg;
        case (state_reg)
            ST_IDLE: begin
                // Ticks are ignored while idle; start counting from zero
                tick_next = '0;
            end
            ST_START: begin
                if (mid_tick) begin
                    tick_next = '0;
                    bit_next  = '0;
                end else if (br_tick) begin
                    tick_next = tick_reg + 1'b1;
                end
            end
            ST_DATA: begin
                if (sample_tick) begin
                    tick_next  = '0;
                    bit_next   = bit_reg + 1'b1;
                    // LSB arrives first, so shift right and insert at the MSB
                    shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                end else if (br_tick) begin
                    tick_next = tick_reg + 1'b1;
                end
            end
            ST_STOP: begin
                if (sample_tick) begin
                    tick_next = '0;
                    data_next = shift_reg;
                    ferr_next = ~rx_s;
                    done_next = 1'b1;
                end else if (br_tick) begin
                    tick_next = tick_reg + 1'b1;
                end
            end
            default: begin
                tick_next = '0;
            end
        endcase
    end

    // Outputs
    assign rx_data   = data_reg;
    assign rx_done   = done_reg;
    assign frame_err = ferr_reg;
    assign rx_busy   = (state_reg != ST_IDLE);

endmodule
